// File: rtl/risc_ctrl_sequencer_if.sv
// rtl/risc_ctrl_sequencer_if.sv - control/handshake bundle between the sequencer and its datapath
interface risc_ctrl_sequencer_if;
    logic       start;
    logic       resume;
    logic       step;
    logic [2:0] opcode;
    logic       acc_zero;
    logic       mem_rdy;
    logic       mrd;
    logic       mwr;
    logic       ld_IR;
    logic       inc_pc;
    logic       ld_pc;
    logic       ldac;
    logic       ALU_setup;
    logic       halted;
    logic       bus_err;
    logic [3:0] state_o;

    modport master (
        output start, resume, step, opcode, acc_zero, mem_rdy,
        input  mrd, mwr, ld_IR, inc_pc, ld_pc, ldac, ALU_setup, halted, bus_err, state_o
    );

    modport slave (
        input  start, resume, step, opcode, acc_zero, mem_rdy,
        output mrd, mwr, ld_IR, inc_pc, ld_pc, ldac, ALU_setup, halted, bus_err, state_o
    );
endinterface

// File: rtl/risc_ctrl_sequencer.sv
// rtl/risc_ctrl_sequencer.sv - fetch/decode/execute sequencer with bounded memory wait
// Optional SINGLE_STEP_EN: each finished instruction parks in IDLE until step/start.
module risc_ctrl_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    risc_ctrl_sequencer_if.slave  bus
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] LOAD_IR = 4'd2;
    localparam logic [3:0] DECODE  = 4'd3;
    localparam logic [3:0] SKIP    = 4'd4;
    localparam logic [3:0] OPRD    = 4'd5;
    localparam logic [3:0] EXEC    = 4'd6;
    localparam logic [3:0] STORE   = 4'd7;
    localparam logic [3:0] JUMP    = 4'd8;
    localparam logic [3:0] HALT    = 4'd9;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

`ifdef SINGLE_STEP_EN
    localparam logic [3:0] NEXT_INSN = IDLE;
    logic go;
    assign go = bus.start | bus.step;
`else
    localparam logic [3:0] NEXT_INSN = FETCH;
    logic go;
    logic unused_step;
    assign go          = bus.start;
    assign unused_step = bus.step;
`endif

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       strb_q, strb_d;
    logic             bus_err_q, bus_err_d;
    logic             in_wait;

    always_comb begin
        state_d   = state_q;
        bus_err_d = 1'b0;
        in_wait   = (state_q == FETCH) || (state_q == OPRD) || (state_q == STORE);
        case (state_q)
            IDLE:    if (go) state_d = FETCH;
            FETCH:   if (bus.mem_rdy) state_d = LOAD_IR;
            LOAD_IR: state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    3'b000:                      state_d = HALT;
                    3'b001:                      state_d = bus.acc_zero ? SKIP : NEXT_INSN;
                    3'b010, 3'b011,
                    3'b100, 3'b101:              state_d = OPRD;
                    3'b110:                      state_d = STORE;
                    default:                     state_d = JUMP;
                endcase
            end
            SKIP:    state_d = NEXT_INSN;
            OPRD:    if (bus.mem_rdy) state_d = EXEC;
            EXEC:    state_d = NEXT_INSN;
            STORE:   if (bus.mem_rdy) state_d = NEXT_INSN;
            JUMP:    state_d = NEXT_INSN;
            HALT:    if (bus.resume) state_d = NEXT_INSN;
            default: state_d = IDLE;
        endcase
        // A ready on the final allowed cycle still completes the access normally.
        if (in_wait && !bus.mem_rdy && (cnt_q == CNT_LAST)) begin
            state_d   = HALT;
            bus_err_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (in_wait && !bus.mem_rdy)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Strobes are decoded from the next state so they line up with state_q after the edge.
    // Bit order: mrd, mwr, ld_IR, inc_pc, ld_pc, ldac, ALU_setup, halted.
    always_comb begin
        strb_d = 8'b0;
        case (state_d)
            FETCH:   strb_d = 8'b1000_0000;
            LOAD_IR: strb_d = 8'b1010_0000;
            DECODE:  strb_d = 8'b0001_0000;
            SKIP:    strb_d = 8'b0001_0000;
            OPRD:    strb_d = 8'b1000_0010;
            EXEC:    strb_d = 8'b0000_0110;
            STORE:   strb_d = 8'b0100_0010;
            JUMP:    strb_d = 8'b0000_1000;
            HALT:    strb_d = 8'b0000_0001;
            default: strb_d = 8'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            strb_q    <= 8'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            strb_q    <= strb_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.mrd       = strb_q[7];
    assign bus.mwr       = strb_q[6];
    assign bus.ld_IR     = strb_q[5];
    assign bus.inc_pc    = strb_q[4];
    assign bus.ld_pc     = strb_q[3];
    assign bus.ldac      = strb_q[2];
    assign bus.ALU_setup = strb_q[1];
    assign bus.halted    = strb_q[0];
    assign bus.bus_err   = bus_err_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_risc_ctrl_sequencer.sv
// tb/tb_risc_ctrl_sequencer.sv - directed and randomized checks against an instruction-level model
module tb_risc_ctrl_sequencer;
    localparam int WM = 4;
`ifdef SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif
    localparam int FE = SS ? 0 : 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_ctrl_sequencer_if bus ();
    risc_ctrl_sequencer #(.WAIT_MAX(WM), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int m_state, m_wait;
    bit m_berr;
    int n_ldir, n_inc, n_ldac, n_mwr, n_alu, n_berr, n_ldpc;

    function automatic logic [7:0] strobes(int s);
        case (s)
            1: return 8'b1000_0000;
            2: return 8'b1010_0000;
            3: return 8'b0001_0000;
            4: return 8'b0001_0000;
            5: return 8'b1000_0010;
            6: return 8'b0000_0110;
            7: return 8'b0100_0010;
            8: return 8'b0000_1000;
            9: return 8'b0000_0001;
            default: return 8'b0;
        endcase
    endfunction

    function automatic logic [7:0] dut_strobes();
        return {bus.mrd, bus.mwr, bus.ld_IR, bus.inc_pc, bus.ld_pc, bus.ldac, bus.ALU_setup, bus.halted};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_ldir = 0; n_inc = 0; n_ldac = 0; n_mwr = 0; n_alu = 0; n_berr = 0; n_ldpc = 0;
    endtask

    task automatic tick();
        int  nxt;
        bit  be;
        bit  waiting;
        nxt = m_state;
        be  = 1'b0;
        waiting = (m_state == 1) || (m_state == 5) || (m_state == 7);
        case (m_state)
            0: if (bus.start || (SS && bus.step)) nxt = 1;
            1: if (bus.mem_rdy) nxt = 2;
            2: nxt = 3;
            3: begin
                if (bus.opcode == 0)      nxt = 9;
                else if (bus.opcode == 1) nxt = bus.acc_zero ? 4 : FE;
                else if (bus.opcode <= 5) nxt = 5;
                else if (bus.opcode == 6) nxt = 7;
                else                      nxt = 8;
            end
            4: nxt = FE;
            5: if (bus.mem_rdy) nxt = 6;
            6: nxt = FE;
            7: if (bus.mem_rdy) nxt = FE;
            8: nxt = FE;
            9: if (bus.resume) nxt = FE;
            default: nxt = 0;
        endcase
        if (waiting && !bus.mem_rdy) begin
            if (m_wait == WM - 1) begin
                nxt = 9;
                be  = 1'b1;
            end else begin
                m_wait++;
            end
        end
        if (nxt != m_state) m_wait = 0;
        @(posedge clk);
        #1;
        m_state = nxt;
        m_berr  = be;
        chk("state_o", bus.state_o, m_state);
        chk("strobes", dut_strobes(), strobes(m_state));
        chk("bus_err", bus.bus_err, m_berr);
        chk("mrd_mwr_excl", bus.mrd & bus.mwr, 0);
        chk("pc_excl", bus.inc_pc & bus.ld_pc, 0);
        n_ldir += bus.ld_IR; n_inc += bus.inc_pc; n_ldac += bus.ldac; n_mwr += bus.mwr;
        n_alu  += bus.ALU_setup; n_berr += bus.bus_err; n_ldpc += bus.ld_pc;
    endtask

    task automatic to_fetch();
        if (m_state == 0) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.resume = 0; bus.step = 0;
        bus.opcode = 0; bus.acc_zero = 0; bus.mem_rdy = 1;
        m_state = 0; m_wait = 0; m_berr = 0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", bus.state_o, 0);
        chk("reset_strobes", dut_strobes(), 0);
        chk("reset_bus_err", bus.bus_err, 0);

        // Reset asserted while OPRD is reading memory
        bus.opcode = 3'b010;
        to_fetch();
        tick(); tick(); tick();
        chk("oprd_mrd", bus.mrd, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", bus.state_o, 0);
        chk("async_rst_strobes", dut_strobes(), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_halted", bus.halted, 0);
        rst = 1'b0;
        m_state = 0; m_wait = 0; m_berr = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_fetch_mrd", bus.mrd, 1);

        // ADD with memory always ready
        clear_counts();
        repeat (5) tick();
        chk("add_end_state", bus.state_o, FE);
        chk("add_ld_IR", n_ldir, 1);
        chk("add_inc_pc", n_inc, 1);
        chk("add_ldac", n_ldac, 1);

        // SKZ taken then not taken
        to_fetch();
        bus.opcode = 3'b001; bus.acc_zero = 1'b1;
        clear_counts();
        repeat (4) tick();
        chk("skz_taken_state", bus.state_o, FE);
        chk("skz_taken_inc", n_inc, 2);
        to_fetch();
        bus.acc_zero = 1'b0;
        clear_counts();
        repeat (3) tick();
        chk("skz_not_state", bus.state_o, FE);
        chk("skz_not_inc", n_inc, 1);

        // STO with three cycles of memory stall
        to_fetch();
        bus.opcode = 3'b110; bus.mem_rdy = 1'b1;
        tick(); tick();
        bus.mem_rdy = 1'b0;
        clear_counts();
        tick(); tick(); tick(); tick();
        bus.mem_rdy = 1'b1;
        tick();
        chk("sto_mwr_cycles", n_mwr, 4);
        chk("sto_alu_cycles", n_alu, 4);
        chk("sto_no_err", n_berr, 0);
        chk("sto_end_state", bus.state_o, FE);

        // Fetch timeout
        to_fetch();
        bus.mem_rdy = 1'b0;
        clear_counts();
        repeat (4) tick();
        chk("timeout_halt", bus.state_o, 9);
        chk("timeout_halted", bus.halted, 1);
        chk("timeout_pulse", bus.bus_err, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("halt_ignores_start", bus.state_o, 9);
        chk("timeout_single", n_berr, 1);
        bus.mem_rdy = 1'b1;
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_state", bus.state_o, FE);

        // JMP
        to_fetch();
        bus.opcode = 3'b111;
        clear_counts();
        repeat (4) tick();
        chk("jmp_ld_pc", n_ldpc, 1);
        chk("jmp_end_state", bus.state_o, FE);
`ifdef SINGLE_STEP_EN
        repeat (3) tick();
        chk("step_parked", bus.state_o, 0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        clear_counts();
        repeat (4) tick();
        chk("step_one_insn", n_ldpc, 1);
        repeat (2) tick();
        chk("step_parked_again", bus.state_o, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.resume   = ($urandom_range(0, 7) == 0);
            bus.step     = ($urandom_range(0, 7) == 0);
            bus.opcode   = 3'($urandom_range(0, 7));
            bus.acc_zero = 1'($urandom_range(0, 1));
            bus.mem_rdy  = ($urandom_range(0, 9) < 6);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_ctrl_sequencer.md
Name: risc_ctrl_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 32-bit accumulator datapath (program counter, instruction register, accumulator, ALU, memory). It produces the datapath strobes from the 3-bit opcode, the accumulator-zero flag and a memory-ready handshake. It adds a bounded memory wait with a timeout to halt.

Parameters:
WAIT_MAX, 15, maximum cycles a memory access may wait for mem_rdy before a bus error (1..255).
CNT_W, 8, width of the wait counter; must hold WAIT_MAX.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  leave IDLE and begin fetching
resume  input  1  leave HALT and fetch next instruction
step  input  1  single-step advance (used only with SINGLE_STEP_EN)
opcode  input  3  opcode field from instruction register
acc_zero  input  1  accumulator == 0
mem_rdy  input  1  memory completes current read/write this cycle
mrd  output  1  memory read enable
mwr  output  1  memory write enable
ld_IR  output  1  load instruction register
inc_pc  output  1  increment program counter
ld_pc  output  1  load program counter from operand address
ldac  output  1  load accumulator from ALU
ALU_setup  output  1  ALU operand/operation enable
halted  output  1  sequencer in HALT
bus_err  output  1  one-cycle pulse on memory timeout
state_o  output  4  current state encoding (debug)

Behaviour:
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- State encodings: IDLE=0, FETCH=1, LOAD_IR=2, DECODE=3, SKIP=4, OPRD=5, EXEC=6, STORE=7, JUMP=8, HALT=9. Other codes go to IDLE.
- All outputs are registered with the state. Outputs in cycle N are the Moore decode of the state held in cycle N. Every strobe not listed for a state is 0.
- Reset (async, any time, including mid-access): state=IDLE, all outputs 0, wait counter 0.
- IDLE: no strobes. start=1 -> FETCH.
- FETCH: mrd=1. mem_rdy=1 -> LOAD_IR.
- LOAD_IR: mrd=1, ld_IR=1 -> DECODE.
- DECODE: inc_pc=1. Next state by opcode:
  - HLT -> HALT.
  - SKZ -> SKIP if acc_zero, else FETCH.
  - ADD/AND/XOR/LDA -> OPRD.
  - STO -> STORE.
  - JMP -> JUMP.
- SKIP: inc_pc=1 -> FETCH.
- OPRD: mrd=1, ALU_setup=1. mem_rdy=1 -> EXEC.
- EXEC: ALU_setup=1, ldac=1 -> FETCH.
- STORE: ALU_setup=1, mwr=1. mem_rdy=1 -> FETCH.
- JUMP: ld_pc=1 -> FETCH.
- HALT: halted=1. resume=1 -> FETCH. start is ignored.
- Wait counter (FETCH, OPRD, STORE):
  - Clears on entry to any of these states; increments each cycle mem_rdy=0.
  - If mem_rdy=0 when count==WAIT_MAX-1: bus_err pulses 1 cycle, next state HALT.
  - mem_rdy=1 on that same cycle wins: normal transition, no error.
- mem_rdy outside the wait states is ignored.
- mrd and mwr are never both 1. inc_pc and ld_pc are never both 1.
- Minimum instruction cycles with mem_rdy tied 1:
  - SKZ not taken: 3. SKZ taken: 4.
  - JMP and STO: 4.
  - ADD/AND/XOR/LDA: 5.

Optional Feature:
Macro SINGLE_STEP_EN.
- Defined: every transition into FETCH (from SKIP, EXEC, STORE, JUMP, DECODE SKZ-not-taken, HALT via resume) goes to IDLE instead. In IDLE, step=1 (or start=1) -> FETCH, so exactly one instruction executes per step pulse.
- Undefined: the step port exists but is ignored, and behaviour is exactly as above.

Test Plan:
- Reset during OPRD with mrd=1 -> next cycle state_o=0, all strobes 0, halted=0. start pulse -> FETCH with mrd=1 one cycle later.
- mem_rdy tied 1, opcode=010 -> sequence FETCH,LOAD_IR,DECODE,OPRD,EXEC. Exactly one ld_IR, one inc_pc, one ldac. Back in FETCH after 5 cycles.
- opcode=001: acc_zero=1 -> 2 inc_pc pulses, FETCH after 4 cycles. acc_zero=0 -> 1 inc_pc, FETCH after 3 cycles.
- opcode=110, mem_rdy low 3 cycles then high -> mwr held 4 cycles, ALU_setup high throughout, no bus_err, then FETCH.
- WAIT_MAX=4, mem_rdy stuck 0 in FETCH -> bus_err single pulse after 4 FETCH cycles, halted=1. resume -> FETCH.
- SINGLE_STEP_EN defined, opcode=111 -> after JUMP (ld_pc=1) state_o=0 and stays there. step pulse -> exactly one further instruction, then IDLE again.
